// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side bus bundle for the ahb_timer peripheral.
// The master modport drives address/control/write data; the slave
// modport returns read data and the ready response.
interface ahb_timer_if;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HTRANS, HWRITE, HSIZE, HADDR, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_timer.sv
// ahb_timer: AHB-Lite 32-bit down-counter timer with reload,
// one-shot/periodic modes and a level interrupt (EXP & IRQEN).
// Optional feature macro: AHB_TIMER_PRESCALE_EN adds a 16-bit
// prescaler; without it the counter ticks every enabled cycle and
// PRESCALE reads as zero.
module ahb_timer #(
  parameter logic [31:0] RST_LOAD = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  ahb_timer_if.slave  bus,
  output logic        timer_irq
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_LOAD   = 3'd1;
  localparam logic [2:0] IDX_VALUE  = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_PRESC  = 3'd4;

  // Latched address phase
  logic       pend_valid_reg;
  logic       pend_write_reg;
  logic       pend_size_ok_reg;
  logic [2:0] pend_idx_reg;

  // Register state
  logic        en_reg;
  logic        periodic_reg;
  logic        irqen_reg;
  logic [31:0] load_reg;
  logic [31:0] value_reg;
  logic        exp_reg;

  logic        addr_ok;
  logic        wr_commit;
  logic        wr_ctrl;
  logic        wr_load;
  logic        wr_status;
  logic        tick;
  logic        expire;
  logic [31:0] prescale_rd;
  logic [31:0] rd_data;
  logic        unused_bus;

  // Address bits outside the register window and HTRANS[0] do not matter.
  assign unused_bus = ^{bus.HADDR[31:5], bus.HADDR[1:0], bus.HTRANS[0]};

  assign addr_ok = bus.HSEL & bus.HREADY & bus.HTRANS[1];

  // A write lands at the end of its data phase; the data phase ends when
  // HREADY is high (always the case for our own zero-wait response).
  assign wr_commit = pend_valid_reg & pend_write_reg & pend_size_ok_reg & bus.HREADY;
  assign wr_ctrl   = wr_commit && (pend_idx_reg == IDX_CTRL);
  assign wr_load   = wr_commit && (pend_idx_reg == IDX_LOAD);
  assign wr_status = wr_commit && (pend_idx_reg == IDX_STATUS);

  assign expire = tick && (value_reg == 32'd0);

  // Capture the address phase of each accepted transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_reg   <= 1'b0;
      pend_write_reg   <= 1'b0;
      pend_size_ok_reg <= 1'b0;
      pend_idx_reg     <= 3'd0;
    end else if (bus.HREADY) begin
      pend_valid_reg   <= addr_ok;
      pend_write_reg   <= bus.HWRITE;
      pend_size_ok_reg <= (bus.HSIZE == 3'b010);
      pend_idx_reg     <= bus.HADDR[4:2];
    end
  end

`ifdef AHB_TIMER_PRESCALE_EN
  logic [15:0] presc_reg;
  logic [15:0] pcnt_reg;
  logic        wr_presc;
  logic        roll;

  assign wr_presc    = wr_commit && (pend_idx_reg == IDX_PRESC);
  assign roll        = (pcnt_reg == presc_reg);
  assign tick        = en_reg & roll;
  assign prescale_rd = {16'h0, presc_reg};

  // PRESCALE register
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_reg <= 16'h0;
    end else if (wr_presc) begin
      presc_reg <= bus.HWDATA[15:0];
    end
  end

  // Prescaler counter: counts enabled cycles 0..PRESCALE, holds while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_reg <= 16'h0;
    end else if (wr_presc) begin
      pcnt_reg <= 16'h0;
    end else if (en_reg) begin
      pcnt_reg <= roll ? 16'h0 : pcnt_reg + 16'd1;
    end
  end
`else
  assign tick        = en_reg;
  assign prescale_rd = 32'h0;
`endif

  // CTRL: a bus write overrides the one-shot auto-disable
  always_ff @(posedge clk) begin
    if (reset) begin
      en_reg       <= 1'b0;
      periodic_reg <= 1'b0;
      irqen_reg    <= 1'b0;
    end else if (wr_ctrl) begin
      en_reg       <= bus.HWDATA[0];
      periodic_reg <= bus.HWDATA[1];
      irqen_reg    <= bus.HWDATA[2];
    end else if (expire && !periodic_reg) begin
      en_reg       <= 1'b0;
    end
  end

  // LOAD register
  always_ff @(posedge clk) begin
    if (reset) begin
      load_reg <= RST_LOAD;
    end else if (wr_load) begin
      load_reg <= bus.HWDATA;
    end
  end

  // VALUE: a LOAD write wins over a simultaneous tick
  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= RST_LOAD;
    end else if (wr_load) begin
      value_reg <= bus.HWDATA;
    end else if (tick) begin
      if (value_reg != 32'd0) begin
        value_reg <= value_reg - 32'd1;
      end else if (periodic_reg) begin
        value_reg <= load_reg;
      end
    end
  end

  // EXP flag: expiry wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_reg <= 1'b0;
    end else if (expire) begin
      exp_reg <= 1'b1;
    end else if (wr_status && bus.HWDATA[0]) begin
      exp_reg <= 1'b0;
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    rd_data = 32'h0;
    if (pend_valid_reg && !pend_write_reg) begin
      case (pend_idx_reg)
        IDX_CTRL:   rd_data = {29'h0, irqen_reg, periodic_reg, en_reg};
        IDX_LOAD:   rd_data = load_reg;
        IDX_VALUE:  rd_data = value_reg;
        IDX_STATUS: rd_data = {31'h0, exp_reg};
        IDX_PRESC:  rd_data = prescale_rd;
        default:    rd_data = 32'h0;
      endcase
    end
  end

  assign bus.HRDATA    = rd_data;
  assign bus.HREADYOUT = 1'b1;
  assign timer_irq     = exp_reg & irqen_reg;

endmodule

// File: tb/tb_ahb_timer.sv
// Directed testbench for ahb_timer: register access, periodic and
// one-shot counting, collision cases, bus filtering and prescaling.
module tb_ahb_timer;

  logic clk = 1'b0;
  logic reset;
  logic timer_irq;

  ahb_timer_if bus();

  ahb_timer #(.RST_LOAD(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_VALUE  = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;
  localparam logic [31:0] A_PRESC  = 32'h10;

`ifdef AHB_TIMER_PRESCALE_EN
  localparam int          PER      = 12;
  localparam logic [31:0] PRESC_RD = 32'd3;
`else
  localparam int          PER      = 3;
  localparam logic [31:0] PRESC_RD = 32'd0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_addr();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HADDR  = 32'h0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr,
                            input logic [2:0] size = 3'b010,
                            input logic [1:0] trans = 2'b10,
                            input logic sel = 1'b1);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HADDR  = a;
  endtask

  // Returns during the data phase cycle; the write commits at the next edge.
  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] size = 3'b010,
                           input logic [1:0] trans = 2'b10,
                           input logic sel = 1'b1);
    step();
    addr_phase(a, 1'b1, size, trans, sel);
    step();
    bus.HWDATA = d;
    idle_addr();
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    step();
    addr_phase(a, 1'b0);
    step();
    idle_addr();
    d = bus.HRDATA;
  endtask

  initial begin
    logic [31:0] d;
    int t;
    int t1;
    int t2;

    reset      = 1'b1;
    bus.HREADY = 1'b1;
    bus.HWDATA = 32'h0;
    idle_addr();
    repeat (3) step();
    reset = 1'b0;

    // Reset state of every offset
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    chk("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      ahb_read(i * 4, d);
      chk($sformatf("rst_off%0h", i * 4), d, 32'h0);
    end

    // Periodic: LOAD=5, PRESCALE=0, CTRL=EN|PERIODIC|IRQEN
    ahb_write(A_LOAD, 32'd5);
    ahb_write(A_PRESC, 32'd0);
    ahb_write(A_CTRL, 32'h7);
    addr_phase(A_VALUE, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      step();
      chk($sformatf("per_value_t%0d", k), bus.HRDATA, 32'(5 - (k % 6)));
      chk($sformatf("per_irq_t%0d", k), {31'h0, timer_irq}, (k >= 6) ? 32'h1 : 32'h0);
    end
    // W1C at t=12 address phase, clear visible from t=14
    addr_phase(A_STATUS, 1'b1);
    step();
    bus.HWDATA = 32'h1;
    idle_addr();
    step();
    chk("w1c_irq_t14", {31'h0, timer_irq}, 32'h0);
    repeat (3) step();
    chk("w1c_irq_t17", {31'h0, timer_irq}, 32'h0);
    step();
    chk("w1c_irq_t18", {31'h0, timer_irq}, 32'h1);
    // W1C commit on the t=24 expiry edge
    repeat (4) step();
    addr_phase(A_STATUS, 1'b1);
    step();
    bus.HWDATA = 32'h1;
    addr_phase(A_STATUS, 1'b0);
    step();
    chk("w1c_vs_expiry_status", bus.HRDATA, 32'h1);
    chk("w1c_vs_expiry_irq", {31'h0, timer_irq}, 32'h1);
    // LOAD write of 10 on a tick edge
    addr_phase(A_LOAD, 1'b1);
    step();
    bus.HWDATA = 32'd10;
    addr_phase(A_VALUE, 1'b0);
    step();
    chk("load_vs_tick", bus.HRDATA, 32'd10);
    idle_addr();
    ahb_write(A_CTRL, 32'h0);
    ahb_write(A_STATUS, 32'h1);

    // One-shot: LOAD=3, CTRL=EN|IRQEN
    ahb_write(A_LOAD, 32'd3);
    ahb_write(A_CTRL, 32'h5);
    repeat (10) step();
    ahb_read(A_CTRL, d);
    chk("oneshot_ctrl", d, 32'h4);
    ahb_read(A_VALUE, d);
    chk("oneshot_value", d, 32'h0);
    ahb_read(A_STATUS, d);
    chk("oneshot_status", d, 32'h1);
    repeat (5) step();
    chk("oneshot_irq_held", {31'h0, timer_irq}, 32'h1);
    ahb_write(A_STATUS, 32'h1);
    step();
    chk("oneshot_irq_cleared", {31'h0, timer_irq}, 32'h0);

    // Bus filtering
    ahb_write(A_LOAD, 32'h55, 3'b000);
    ahb_read(A_LOAD, d);
    chk("filt_byte", d, 32'd3);
    ahb_write(A_LOAD, 32'h66, 3'b010, 2'b00);
    ahb_read(A_LOAD, d);
    chk("filt_idle", d, 32'd3);
    ahb_write(A_LOAD, 32'h67, 3'b010, 2'b01);
    ahb_read(A_LOAD, d);
    chk("filt_busy", d, 32'd3);
    ahb_write(A_LOAD, 32'h77, 3'b010, 2'b10, 1'b0);
    ahb_read(A_LOAD, d);
    chk("filt_hsel", d, 32'd3);
    ahb_write(A_VALUE, 32'h88);
    ahb_read(A_VALUE, d);
    chk("filt_value_ro", d, 32'd0);
    ahb_write(32'h14, 32'h99);
    ahb_read(32'h14, d);
    chk("filt_off14", d, 32'd0);
    // Back-to-back write then read of LOAD
    step();
    addr_phase(A_LOAD, 1'b1);
    step();
    bus.HWDATA = 32'h1234_5678;
    addr_phase(A_LOAD, 1'b0);
    step();
    chk("b2b_load", bus.HRDATA, 32'h1234_5678);
    idle_addr();
    ahb_read(A_VALUE, d);
    chk("b2b_value_copy", d, 32'h1234_5678);

    // Prescaled period: PRESCALE=3, LOAD=2, periodic with IRQEN
    ahb_write(A_PRESC, 32'd3);
    ahb_read(A_PRESC, d);
    chk("presc_read", d, PRESC_RD);
    ahb_write(A_LOAD, 32'd2);
    ahb_write(A_STATUS, 32'h1);
    ahb_write(A_CTRL, 32'h7);
    step();
    t = 0;
    while (timer_irq !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    t1 = t;
    chk("presc_first_expiry", 32'(t1), 32'(PER));
    addr_phase(A_STATUS, 1'b1);
    step();
    bus.HWDATA = 32'h1;
    idle_addr();
    step();
    t = t1 + 2;
    chk("presc_w1c_irq", {31'h0, timer_irq}, 32'h0);
    while (timer_irq !== 1'b1 && t < 80) begin
      step();
      t++;
    end
    t2 = t;
    chk("presc_period", 32'(t2 - t1), 32'(PER));

    // Mid-operation reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_irq", {31'h0, timer_irq}, 32'h0);
    ahb_read(A_CTRL, d);
    chk("midrst_ctrl", d, 32'h0);
    ahb_read(A_LOAD, d);
    chk("midrst_load", d, 32'h0);
    ahb_read(A_PRESC, d);
    chk("midrst_presc", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_timer.md
# ahb_timer

AHB-Lite slave timer peripheral on the SoC bus, on a free slave select next to the UART and GPIO slaves. It provides a 32-bit down-counter with reload, one-shot/periodic modes and a level interrupt. The interrupt drives one bit of the CPU `cpu_irq` vector, which is currently tied to zero.

## Interface
Parameters:
- `RST_LOAD`, 32'h0: reset value of LOAD and VALUE.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: reset. Synchronous, active-high. One clock drives the whole block.
- `HSEL`, in, 1: slave select, active-high (top inverts the bus `cs_`).
- `HREADY`, in, 1: bus ready; the address phase is accepted only when high.
- `HTRANS`, in, 2: transfer type; valid when `HTRANS[1]`=1 (NONSEQ/SEQ).
- `HWRITE`, in, 1: 1 = write.
- `HSIZE`, in, 3: transfer size; only 3'b010 (word) writes take effect.
- `HADDR`, in, 32: address; `HADDR[4:2]` selects the register.
- `HWDATA`, in, 32: write data, sampled in the data phase.
- `HRDATA`, out, 32: read data, valid in the data phase.
- `HREADYOUT`, out, 1: constant 1 (zero wait states).
- `timer_irq`, out, 1: level interrupt, active-high.

## Operation
Register map (word offsets):
- 0x00 CTRL, RW.
  - bit0 EN: counter runs.
  - bit1 PERIODIC: 1 = reload on expiry, 0 = one-shot.
  - bit2 IRQEN: gates `timer_irq`.
  - bits[31:3] read 0.
- 0x04 LOAD, RW. A write also copies the written value into VALUE.
- 0x08 VALUE, RO. Current count; writes are ignored.
- 0x0C STATUS.
  - bit0 EXP: set on expiry.
  - Write 1 to bit0 clears it; writing 0 has no effect.
- 0x10 PRESCALE, RW. Bits[15:0]; see Configuration.
- Offsets 0x14–0x1C read 0; writes to them are ignored.

Address-phase capture:
- Condition: `HSEL & HREADY & HTRANS[1]`.
- Latched: `HWRITE`, `HADDR[4:2]`, and a size-ok flag (`HSIZE`==3'b010).

Data-phase write:
- Commits `HWDATA` to the latched register at the end of the data phase.
- Visible from the next cycle.

Data-phase read:
- `HRDATA` is a combinational mux of the latched register index.
- Outside read data phases it drives 0.

Counter behaviour:
- A tick occurs every cycle in which EN=1 and the prescaler rolls over.
- On a tick with VALUE≠0: VALUE decrements by 1.
- On a tick with VALUE==0: EXP←1.
  - PERIODIC=1: VALUE←LOAD.
  - PERIODIC=0: EN←0 and VALUE stays 0.
- LOAD=0 in periodic mode: expiry on every tick.

`timer_irq` = EXP & IRQEN.

Simultaneous events:
- An expiry in the same cycle as a STATUS W1C: expiry wins, EXP stays 1.
- A LOAD write in the same cycle as a tick: the written value wins for VALUE. Expiry from the pre-write VALUE==0 still sets EXP.
- A CTRL write in the same cycle as a one-shot expiry: the written EN wins.
- An IDLE/BUSY transfer, or `HSEL` low, causes no register access.

Reset:
- Mid-operation reset returns every register to its reset value on the next edge.
- Any latched pending transfer is discarded.

## Timing
Reset values:
- CTRL=0, STATUS=0, PRESCALE=0, prescaler counter=0.
- LOAD=VALUE=`RST_LOAD`.
- `HRDATA`=0, `timer_irq`=0, `HREADYOUT`=1.

Latencies:
- Write: an address phase at cycle N, with data at cycle N+1, gives the register updated at edge N+1→N+2.
- Read: an address phase at N gives `HRDATA` valid during N+1.
- Back-to-back transfers are supported: a write followed by a read of the same register returns the new value.
- Expiry: a tick at VALUE==0 on edge E sets EXP, and `timer_irq` is high in the cycle after E.
- Count rate: one decrement per PRESCALE+1 enabled cycles. A period in periodic mode is (LOAD+1)·(PRESCALE+1) cycles.
- Enabling: EN set by a write is first effective in the cycle after the write commits.

## Configuration
Macro: `AHB_TIMER_PRESCALE_EN`.

Defined:
- A 16-bit prescaler counter counts enabled cycles 0..PRESCALE and produces a tick on reaching PRESCALE, then wraps to 0.
- Writing PRESCALE resets the prescaler counter to 0.
- Clearing EN holds the prescaler counter.

Not defined:
- Tick = EN every cycle.
- PRESCALE reads 0 and writes to it are ignored.
- No prescaler logic is synthesized.

## Test plan
- Reset then read all offsets → CTRL=0, LOAD=VALUE=0, STATUS=0, PRESCALE=0, `timer_irq`=0, `HREADYOUT`=1.
- LOAD=5, CTRL=0x7 (EN, PERIODIC, IRQEN), PRESCALE=0:
  - VALUE reads 5,4,…,0,5.
  - EXP and `timer_irq` rise 6 cycles after EN takes effect, and repeat every 6 cycles.
  - W1C to STATUS drops the IRQ for one period.
- One-shot: LOAD=3, CTRL=0x5 → after expiry, CTRL reads 0x4, VALUE stays 0, `timer_irq` stays 1 until W1C.
- Collision: a STATUS W1C committed in the same cycle as an expiry → EXP reads 1.
  - A LOAD write of 10 in the same cycle as a tick → VALUE reads 10.
- Bus filtering: a byte write (HSIZE=0) to LOAD, an IDLE transfer, and `HSEL`=0 → registers unchanged. A back-to-back write then read of LOAD returns the new value.
- With `AHB_TIMER_PRESCALE_EN`: PRESCALE=3, LOAD=2, periodic → expiry every 12 cycles.
- Without `AHB_TIMER_PRESCALE_EN`: the same setup expires every 3 cycles, and PRESCALE reads 0.
